regfile_wb_queue: RTL

//   Write-back initiator for the 32x32 register file. Accepts register-write

---
 rtl/regfile_wb_queue_if.sv | 26 ++
 rtl/regfile_wb_queue.sv | 117 +++++++++++
 2 files changed

// File: rtl/regfile_wb_queue_if.sv
// Write-request channel from the datapath into the register-file write-back queue.
interface regfile_wb_queue_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_rw;
    logic [DATA_WIDTH-1:0] in_data;

    // Datapath side: issues write requests.
    modport master (
        output in_valid,
        output in_rw,
        output in_data,
        input  in_ready
    );

    // Queue side: accepts write requests.
    modport slave (
        input  in_valid,
        input  in_rw,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// Register-file write-back queue: in-order buffering of write requests,
// one drain per cycle onto the write port, newest-first read forwarding.
module regfile_wb_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DROP_R0    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    regfile_wb_queue_if.slave             req,
    input  logic                          wb_hold,
    output logic                          RegWr,
    output logic [ADDR_WIDTH-1:0]         Rw,
    output logic [DATA_WIDTH-1:0]         busW,
    input  logic [ADDR_WIDTH-1:0]         Ra,
    input  logic [ADDR_WIDTH-1:0]         Rb,
    output logic                          hit_a,
    output logic [DATA_WIDTH-1:0]         fwd_a,
    output logic                          hit_b,
    output logic [DATA_WIDTH-1:0]         fwd_b,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam bit          DROP  = (DROP_R0 != 0);

    logic [PTR_W-1:0]      rd_q, rd_d;
    logic [PTR_W-1:0]      wr_q, wr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] rw_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];

    logic pop_c;
    logic accept_c;
    logic push_c;
    logic nonempty_c;

    assign nonempty_c   = (count_q != '0);
    assign pop_c        = nonempty_c && !wb_hold;
    assign req.in_ready = (count_q < CNT_W'(DEPTH)) || pop_c;
    assign accept_c     = req.in_valid && req.in_ready;
    assign push_c       = accept_c && !(DROP && (req.in_rw == '0));

    // Write port: head entry is presented whenever one is pending.
    assign RegWr = pop_c && rst_n;
    assign Rw    = nonempty_c ? rw_q[rd_q]   : '0;
    assign busW  = nonempty_c ? data_q[rd_q] : '0;
    assign count = count_q;

    // Next-state for pointers, occupancy and entry valid bits.
    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        valid_d = valid_q;
        if (pop_c) begin
            rd_d          = rd_q + PTR_W'(1);
            valid_d[rd_q] = 1'b0;
        end
        if (push_c) begin
            wr_d          = wr_q + PTR_W'(1);
            valid_d[wr_q] = 1'b1;
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset discarding all pending writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload storage; validity is tracked separately so no reset needed.
    always_ff @(posedge clk) begin
        if (push_c && rst_n) begin
            rw_q[wr_q]   <= req.in_rw;
            data_q[wr_q] <= req.in_data;
        end
    end

    // Forwarding: scan oldest to newest so the newest matching entry wins.
    always_comb begin
        hit_a = 1'b0;
        fwd_a = '0;
        hit_b = 1'b0;
        fwd_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[rd_q + PTR_W'(i)] && (rw_q[rd_q + PTR_W'(i)] == Ra)
                && !(DROP && (Ra == '0))) begin
                hit_a = 1'b1;
                fwd_a = data_q[rd_q + PTR_W'(i)];
            end
            if (valid_q[rd_q + PTR_W'(i)] && (rw_q[rd_q + PTR_W'(i)] == Rb)
                && !(DROP && (Rb == '0))) begin
                hit_b = 1'b1;
                fwd_b = data_q[rd_q + PTR_W'(i)];
            end
        end
    end

endmodule
